alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
Initiator that drives the 8-bit accumulator ALU's control and operand pins from a host command stream.
- Accepts one command at a time over a valid/ready handshake and translates it to the ALU's one-hot input and output selectors.
- Waits a fixed settle time, captures the ALU result and error state, and returns them over a valid/ready response channel.
- Sits between the host or test controller and the ALU.

Parameters:
SETTLE_CYCLES, 2, cycles from issuing a command to the ALU to sampling its result; legal range 2..15.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  host command valid
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MULT, 7 CLEAR
cmd_chain  input  1  1: use the previous result as operand A instead of cmd_a
cmd_a  input  8  operand A
cmd_b  input  8  operand B
rsp_valid  output  1  response valid
rsp_ready  input  1  host accepts response
rsp_data  output  8  captured ALU result
rsp_error  output  1  ALU was in run_error state at sample time
alu_on  output  1  ALU power/enable
alu_in_selector  output  3  one-hot: bit2 persist, bit1 load, bit0 reset
alu_num1  output  8  ALU accumulator operand
alu_num2  output  8  ALU second operand
alu_out_selector  output  7  one-hot: bit6 AND, bit5 OR, bit4 NOT, bit3 XOR, bit2 ADD, bit1 SUB, bit0 MULT
alu_result  input  8  ALU output value
alu_state  input  2  ALU FSM state: 00 off, 01 ready, 10 run, 11 run_error

Behaviour:
- All outputs are registered. Internal acc_q holds the last captured result.
- Reset state (rst=1 at an edge):
  - FSM goes to INIT.
  - alu_on=0, alu_in_selector=3'b001, alu_num1=0, alu_num2=0, alu_out_selector=7'b1000000.
  - cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_error=0, acc_q=0.
- INIT: lasts one cycle after rst deasserts.
  - alu_on=1, alu_in_selector=3'b001.
  - Then goes to IDLE.
- IDLE:
  - cmd_ready=1.
  - alu_in_selector=3'b010 (load), alu_num1=acc_q, alu_num2=0. This holds the ALU accumulator stable.
  - Persist (3'b100) is never driven, because a persisted accumulator re-executes the operation every cycle.
- Accept edge T (cmd_valid & cmd_ready), cmd_op 0..6:
  - Register alu_in_selector=3'b010.
  - alu_num1 = cmd_chain ? acc_q : cmd_a; alu_num2=cmd_b; alu_out_selector = one-hot of cmd_op.
  - Load the wait counter with SETTLE_CYCLES and go to WAIT. cmd_ready drops at T.
- Accept edge T, cmd_op 7 (CLEAR):
  - alu_in_selector=3'b001 for exactly one cycle; acc_q cleared.
  - Go to RESP with rsp_data=0, rsp_error=0, rsp_valid=1 at edge T+1.
- WAIT:
  - Counter decrements each edge. Drives are held.
  - At the edge where the counter equals 1 (edge T+SETTLE_CYCLES): rsp_data=alu_result, acc_q=alu_result, rsp_error=(alu_state==2'b11), rsp_valid=1. Go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_error are held stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid=0, go to IDLE; cmd_ready=1 from the next cycle.
  - Back-to-back throughput is therefore one command per SETTLE_CYCLES+2 cycles.
- Chained commands:
  - An error response still updates acc_q.
  - A chained command after an error uses the captured (truncated) value.
- rst during any state:
  - Aborts the operation; no response is produced.
  - All reset values apply and INIT is re-run.
- cmd_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.

Optional Feature:
ALU_ERR_COUNT_EN
- Defined: adds output err_count [7:0].
  - Increments, saturating at 255, on every response handshake with rsp_error=1.
  - Cleared by rst and by a CLEAR command.
- Undefined: port and logic absent. Behaviour is otherwise identical.

Test Plan:
1. Reset, then ADD a=5 b=3 chain=0 accepted at edge T -> alu_out_selector=7'b0000100 at T; rsp_valid at T+2; rsp_data=8, rsp_error=0.
2. Follow with SUB chain=1 b=2 -> alu_num1=8; rsp_data=6. Then NOT chain=1 -> rsp_data=8'hF9.
3. MULT a=8'h20 b=8'h10 with the ALU model entering state 11 -> rsp_error=1, rsp_data=low 8 bits (8'h00); err_count=1 when ALU_ERR_COUNT_EN is defined.
4. rsp_ready held low 6 cycles after rsp_valid -> rsp_valid and rsp_data unchanged; cmd_ready=0 throughout; a cmd_valid pulse in that window is ignored.
5. CLEAR after a result of 6 -> alu_in_selector=3'b001 for one cycle; rsp_data=0; a following chained ADD b=4 returns 4.
6. Assert rst in WAIT after an accepted XOR -> no rsp_valid; outputs at reset values; INIT drives alu_on=1 and the reset selector one cycle; cmd_ready=1 two cycles after rst drops.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Host command sequencer for the 8-bit accumulator ALU: handshake in, settle, capture, handshake out.
// Optional macro ALU_ERR_COUNT_EN adds o_err_count (saturating count of error responses).
//
// state | meaning
// INIT  | one cycle after reset: power the ALU and hold its reset selector
// IDLE  | hold accumulator via load of acc, accept a command
// WAIT  | drives held, settle counter runs down to terminal count 1
// CLR   | one cycle of ALU reset selector for a CLEAR command
// RESP  | response held until host accepts it
module alu_cmd_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [2:0] i_cmd_op,
    input  logic       i_cmd_chain,
    input  logic [7:0] i_cmd_a,
    input  logic [7:0] i_cmd_b,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic [7:0] o_rsp_data,
    output logic       o_rsp_error,
    output logic       o_alu_on,
    output logic [2:0] o_alu_in_selector,
    output logic [7:0] o_alu_num1,
    output logic [7:0] o_alu_num2,
    output logic [6:0] o_alu_out_selector,
    input  logic [7:0] i_alu_result,
    input  logic [1:0] i_alu_state
`ifdef ALU_ERR_COUNT_EN
    ,
    output logic [7:0] o_err_count
`endif
);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WAIT, S_CLR, S_RESP} state_t;

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);
    localparam logic [2:0] LP_SEL_PERSIST_UNUSED = 3'b100;
    localparam logic [2:0] LP_SEL_LOAD  = 3'b010;
    localparam logic [2:0] LP_SEL_RESET = 3'b001;
    localparam logic [2:0] LP_OP_CLEAR  = 3'd7;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_acc, w_acc_nxt;
    logic       r_cmd_ready, w_cmd_ready_nxt;
    logic       r_rsp_valid, w_rsp_valid_nxt;
    logic [7:0] r_rsp_data, w_rsp_data_nxt;
    logic       r_rsp_error, w_rsp_error_nxt;
    logic       r_alu_on, w_alu_on_nxt;
    logic [2:0] r_in_sel, w_in_sel_nxt;
    logic [7:0] r_num1, w_num1_nxt;
    logic [7:0] r_num2, w_num2_nxt;
    logic [6:0] r_out_sel, w_out_sel_nxt;
`ifdef ALU_ERR_COUNT_EN
    logic [7:0] r_err_count, w_err_count_nxt;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_acc_nxt       = r_acc;
        w_cmd_ready_nxt = r_cmd_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_error_nxt = r_rsp_error;
        w_alu_on_nxt    = r_alu_on;
        w_in_sel_nxt    = r_in_sel;
        w_num1_nxt      = r_num1;
        w_num2_nxt      = r_num2;
        w_out_sel_nxt   = r_out_sel;
`ifdef ALU_ERR_COUNT_EN
        w_err_count_nxt = r_err_count;
`endif
        case (r_state)
            S_INIT: begin
                w_alu_on_nxt = 1'b1;
                w_in_sel_nxt = LP_SEL_RESET;
                w_state_nxt  = S_IDLE;
            end
            S_IDLE: begin
                // Persist is never used: it would re-run the operation every cycle.
                w_cmd_ready_nxt = 1'b1;
                w_in_sel_nxt    = LP_SEL_LOAD;
                w_num1_nxt      = r_acc;
                w_num2_nxt      = 8'd0;
                if (i_cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    if (i_cmd_op == LP_OP_CLEAR) begin
                        w_in_sel_nxt = LP_SEL_RESET;
                        w_acc_nxt    = 8'd0;
                        w_num1_nxt   = 8'd0;
                        w_state_nxt  = S_CLR;
`ifdef ALU_ERR_COUNT_EN
                        w_err_count_nxt = 8'd0;
`endif
                    end else begin
                        w_num1_nxt    = i_cmd_chain ? r_acc : i_cmd_a;
                        w_num2_nxt    = i_cmd_b;
                        w_out_sel_nxt = 7'(7'b1000000 >> i_cmd_op);
                        w_cnt_nxt     = LP_SETTLE;
                        w_state_nxt   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_rsp_data_nxt  = i_alu_result;
                    w_acc_nxt       = i_alu_result;
                    w_rsp_error_nxt = (i_alu_state == 2'b11);
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = S_RESP;
                end
            end
            S_CLR: begin
                w_in_sel_nxt    = LP_SEL_LOAD;
                w_rsp_data_nxt  = 8'd0;
                w_rsp_error_nxt = 1'b0;
                w_rsp_valid_nxt = 1'b1;
                w_state_nxt     = S_RESP;
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_in_sel_nxt    = LP_SEL_LOAD;
                    w_num1_nxt      = r_acc;
                    w_num2_nxt      = 8'd0;
                    w_state_nxt     = S_IDLE;
`ifdef ALU_ERR_COUNT_EN
                    if (r_rsp_error && (r_err_count != 8'hFF))
                        w_err_count_nxt = r_err_count + 8'd1;
`endif
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_INIT;
            r_cnt       <= 4'd0;
            r_acc       <= 8'd0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'd0;
            r_rsp_error <= 1'b0;
            r_alu_on    <= 1'b0;
            r_in_sel    <= LP_SEL_RESET;
            r_num1      <= 8'd0;
            r_num2      <= 8'd0;
            r_out_sel   <= 7'b1000000;
`ifdef ALU_ERR_COUNT_EN
            r_err_count <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_acc       <= w_acc_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_error <= w_rsp_error_nxt;
            r_alu_on    <= w_alu_on_nxt;
            r_in_sel    <= w_in_sel_nxt;
            r_num1      <= w_num1_nxt;
            r_num2      <= w_num2_nxt;
            r_out_sel   <= w_out_sel_nxt;
`ifdef ALU_ERR_COUNT_EN
            r_err_count <= w_err_count_nxt;
`endif
        end
    end

    assign o_cmd_ready        = r_cmd_ready;
    assign o_rsp_valid        = r_rsp_valid;
    assign o_rsp_data         = r_rsp_data;
    assign o_rsp_error        = r_rsp_error;
    assign o_alu_on           = r_alu_on;
    assign o_alu_in_selector  = r_in_sel;
    assign o_alu_num1         = r_num1;
    assign o_alu_num2         = r_num2;
    assign o_alu_out_selector = r_out_sel;
`ifdef ALU_ERR_COUNT_EN
    assign o_err_count        = r_err_count;
`endif

endmodule
